// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC sequencing with jump/branch, a loadable instruction
// memory and an IDLE/RUN/HALT controller. Define IFU_FETCH_COUNT_EN to add fetch_count.
//
// state  | meaning
// S_IDLE | PC held at RESET_PC, program load allowed, waits for start
// S_RUN  | fetching; PC advances to next_pc on every unstalled edge
// S_HALT | halt opcode or out-of-range target seen; PC frozen, program load allowed
module instr_fetch_unit #(
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic        stall,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    input  logic        imem_we,
    input  logic [31:0] imem_addr,
    input  logic [31:0] imem_wdata,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        valid,
    output logic        halted
`ifdef IFU_FETCH_COUNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    localparam int          AW         = $clog2(IMEM_DEPTH);
    localparam logic [31:0] IMEM_BYTES = 32'(4 * IMEM_DEPTH);
    localparam logic [31:0] HALT_INSTR = 32'hFC00_0000;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    logic [1:0]  state;
    logic [31:0] imem [IMEM_DEPTH];
    logic [31:0] next_pc_raw;
    logic [31:0] next_pc;
    logic [31:0] branch_off;
    logic        pc_in_range;
    logic        load_in_range;
    logic        halt_cond;
    logic        fetch_en;

    assign pc_plus4      = pc + 32'd4;
    assign pc_in_range   = (pc < IMEM_BYTES);
    assign load_in_range = (imem_addr < IMEM_BYTES);
    assign instr         = pc_in_range ? imem[pc[AW+1:2]] : 32'h0000_0000;
    assign branch_off    = {{14{instr[15]}}, instr[15:0], 2'b00};

    always_comb begin
        next_pc_raw = pc_plus4;
        if (jump)
            next_pc_raw = {pc_plus4[31:28], instr[25:0], 2'b00};
        else if (branch && zero)
            next_pc_raw = pc_plus4 + branch_off;
    end

    // Force word alignment even if RESET_PC was misconfigured.
    assign next_pc   = {next_pc_raw[31:2], 2'b00};
    assign halt_cond = (instr == HALT_INSTR) || (next_pc >= IMEM_BYTES);
    assign fetch_en  = (state == S_RUN) && !stall;

    assign valid  = (state == S_RUN);
    assign halted = (state == S_HALT);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
        end else begin
            case (state)
                S_IDLE: if (start) state <= S_RUN;
                S_RUN: begin
                    if (fetch_en) begin
                        if (halt_cond) state <= S_HALT;
                        else           pc    <= next_pc;
                    end
                end
                S_HALT: begin
                    if (start) begin
                        state <= S_IDLE;
                        pc    <= RESET_PC;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef IFU_FETCH_COUNT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            fetch_count <= 32'd0;
        else if (fetch_en && !halt_cond)
            fetch_count <= fetch_count + 32'd1;
    end
`endif

    // Memory is deliberately not reset so a program survives RST.
    always_ff @(posedge CLK) begin
        if (imem_we && (state != S_RUN) && load_in_range)
            imem[imem_addr[AW+1:2]] <= imem_wdata;
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (default depth 256, RESET_PC 0).
module tb_instr_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        start = 1'b0, stall = 1'b0, branch = 1'b0, zero = 1'b0, jump = 1'b0;
    logic        imem_we = 1'b0;
    logic [31:0] imem_addr = 32'd0, imem_wdata = 32'd0;
    logic [31:0] instr, pc, pc_plus4;
    logic        valid, halted;
`ifdef IFU_FETCH_COUNT_EN
    logic [31:0] fetch_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] W0  = 32'h0000_0001;
    localparam logic [31:0] W1  = 32'h0800_0010;
    localparam logic [31:0] W2  = 32'h1000_FFFE;
    localparam logic [31:0] W3  = 32'h0000_0003;
    localparam logic [31:0] W4  = 32'h1000_0400;
    localparam logic [31:0] W5  = 32'hFC00_0000;
    localparam logic [31:0] W16 = 32'h0000_0016;
    localparam logic [31:0] W17 = 32'hFC00_0000;

    instr_fetch_unit dut (
        .CLK(CLK), .RST(RST), .start(start), .stall(stall), .branch(branch),
        .zero(zero), .jump(jump), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .instr(instr), .pc(pc), .pc_plus4(pc_plus4),
        .valid(valid), .halted(halted)
`ifdef IFU_FETCH_COUNT_EN
        , .fetch_count(fetch_count)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        imem_we = 1'b1; imem_addr = a; imem_wdata = d;
        tick();
        imem_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        n_cmp++; if (pc !== 32'd0) begin n_err++; $display("FAIL reset_pc got %h want %h", pc, 32'd0); end
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", valid); end
        n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted got %b want 0", halted); end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_load();
        load(32'h0, 32'hAAAA_0000);
        n_cmp++; if (instr !== 32'hAAAA_0000) begin n_err++; $display("FAIL load_cur_word got %h want %h", instr, 32'hAAAA_0000); end
        load(32'h3, W0);
        n_cmp++; if (instr !== W0) begin n_err++; $display("FAIL load_lsb_ignored got %h want %h", instr, W0); end
        load(32'h4, W1);  load(32'h8, W2);  load(32'hC, W3);
        load(32'h10, W4); load(32'h14, W5); load(32'h40, W16); load(32'h44, W17);
        load(32'h400, 32'hDEAD_BEEF);
        n_cmp++; if (instr !== W0) begin n_err++; $display("FAIL load_oor_dropped got %h want %h", instr, W0); end
        tick();
        n_cmp++; if (pc !== 32'd0 || valid !== 1'b0) begin n_err++; $display("FAIL idle_hold got pc=%h valid=%b want pc=0 valid=0", pc, valid); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        pulse_start();
        n_cmp++; if (valid !== 1'b1 || pc !== 32'd0) begin n_err++; $display("FAIL run_entry got pc=%h valid=%b want pc=0 valid=1", pc, valid); end
        n_cmp++; if (pc_plus4 !== 32'd4) begin n_err++; $display("FAIL pc_plus4 got %h want %h", pc_plus4, 32'd4); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            exp_pc = 32'(4 * i);
            n_cmp++; if (pc !== exp_pc) begin n_err++; $display("FAIL seq_pc got %h want %h", pc, exp_pc); end
        end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start = (i == 1);
            tick();
            n_cmp++; if (pc !== 32'd12 || valid !== 1'b1) begin n_err++; $display("FAIL stall_hold got pc=%h valid=%b want pc=c valid=1", pc, valid); end
`ifdef IFU_FETCH_COUNT_EN
            n_cmp++; if (fetch_count !== 32'd3) begin n_err++; $display("FAIL stall_count got %0d want 3", fetch_count); end
`endif
        end
        start = 1'b0; stall = 1'b0;
        tick();
        n_cmp++; if (pc !== 32'd16) begin n_err++; $display("FAIL stall_release got %h want %h", pc, 32'd16); end
        tick();
        n_cmp++; if (pc !== 32'd20 || instr !== W5) begin n_err++; $display("FAIL pre_halt got pc=%h instr=%h want pc=14 instr=%h", pc, instr, W5); end
        tick();
        n_cmp++; if (halted !== 1'b1 || valid !== 1'b0 || pc !== 32'd20) begin n_err++; $display("FAIL halt_op got pc=%h h=%b v=%b want pc=14 h=1 v=0", pc, halted, valid); end
`ifdef IFU_FETCH_COUNT_EN
        n_cmp++; if (fetch_count !== 32'd5) begin n_err++; $display("FAIL halt_count got %0d want 5", fetch_count); end
`endif
        load(32'h0, 32'h2222_0000);
        pulse_start();
        n_cmp++; if (halted !== 1'b0 || valid !== 1'b0 || pc !== 32'd0) begin n_err++; $display("FAIL halt_to_idle got pc=%h h=%b v=%b want pc=0 h=0 v=0", pc, halted, valid); end
        n_cmp++; if (instr !== 32'h2222_0000) begin n_err++; $display("FAIL halt_write got %h want %h", instr, 32'h2222_0000); end
        load(32'h0, W0);
    endtask

    task automatic test_branch_jump();
        pulse_start();
        tick(); tick();
        branch = 1'b1; zero = 1'b1;
        tick();
        n_cmp++; if (pc !== 32'd4) begin n_err++; $display("FAIL beq_taken got %h want %h", pc, 32'd4); end
        jump = 1'b1;
        tick();
        n_cmp++; if (pc !== 32'h40 || instr !== W16) begin n_err++; $display("FAIL jump_prio got pc=%h instr=%h want pc=40 instr=%h", pc, instr, W16); end
        jump = 1'b0; branch = 1'b0; zero = 1'b0;
        tick();
        n_cmp++; if (pc !== 32'h44) begin n_err++; $display("FAIL after_jump got %h want %h", pc, 32'h44); end
        tick();
        n_cmp++; if (halted !== 1'b1 || pc !== 32'h44) begin n_err++; $display("FAIL jump_halt got pc=%h h=%b want pc=44 h=1", pc, halted); end
        pulse_start();
        pulse_start();
        tick(); tick();
        branch = 1'b1; zero = 1'b0;
        tick();
        n_cmp++; if (pc !== 32'd12) begin n_err++; $display("FAIL beq_not_taken got %h want %h", pc, 32'd12); end
        branch = 1'b0;
        tick();
        stall = 1'b1; branch = 1'b1; zero = 1'b1;
        tick();
        n_cmp++; if (halted !== 1'b0 || pc !== 32'd16) begin n_err++; $display("FAIL stall_blocks_halt got pc=%h h=%b want pc=10 h=0", pc, halted); end
        stall = 1'b0;
        tick();
        n_cmp++; if (halted !== 1'b1 || pc !== 32'd16) begin n_err++; $display("FAIL oor_halt got pc=%h h=%b want pc=10 h=1", pc, halted); end
        branch = 1'b0; zero = 1'b0;
        pulse_start();
    endtask

    task automatic test_run_write_ignored();
        pulse_start();
        stall = 1'b1;
        load(32'h0, 32'h3333_3333);
        n_cmp++; if (instr !== W0) begin n_err++; $display("FAIL run_write got %h want %h", instr, W0); end
        stall = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        for (int i = 0; i < 4; i++) tick();
        n_cmp++; if (pc !== 32'd16) begin n_err++; $display("FAIL pre_reset_pc got %h want %h", pc, 32'd16); end
        #2 RST = 1'b1;
        #1;
        n_cmp++; if (pc !== 32'd0 || valid !== 1'b0 || halted !== 1'b0) begin n_err++; $display("FAIL async_reset got pc=%h v=%b h=%b want pc=0 v=0 h=0", pc, valid, halted); end
        RST = 1'b0;
        tick();
        n_cmp++; if (pc !== 32'd0 || valid !== 1'b0) begin n_err++; $display("FAIL post_reset_idle got pc=%h v=%b want pc=0 v=0", pc, valid); end
`ifdef IFU_FETCH_COUNT_EN
        n_cmp++; if (fetch_count !== 32'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", fetch_count); end
`endif
        pulse_start();
        n_cmp++; if (instr !== W0) begin n_err++; $display("FAIL keep_w0 got %h want %h", instr, W0); end
        tick();
        n_cmp++; if (instr !== W1) begin n_err++; $display("FAIL keep_w1 got %h want %h", instr, W1); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_sequential();
        test_branch_jump();
        test_run_write_ignored();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
